muldiv_hilo: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in EX beside the ALU.
- Consumes the same register operands the ALU operand-select path delivers (rs/rt values).
- Returns results through HI/LO toward the writeback select path (MFHI/MFLO).
- Iterative radix-2 datapath, 32 iterations, with a start/busy/done handshake to the pipeline stall logic.

---
 rtl/muldiv_hilo_pkg.sv | 28 ++
 rtl/muldiv_hilo_cond_negate.sv | 12 +
 rtl/muldiv_hilo.sv | 143 ++++++++++++++
 tb/tb_muldiv_hilo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_pkg.sv
// Shared op codes, FSM states and decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Codes 0..3 are the iterative ops; bit 1 separates divide from multiply.
  function automatic logic op_is_iter(input logic [2:0] op);
    return !op[2];
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_cond_negate.sv
// Combinational conditional two's-complement negate; zero latency, no flow control.
module cond_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  assign o_dat = i_neg ? (~i_dat + W'(1)) : i_dat;

endmodule

// File: rtl/muldiv_hilo.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO; 33 busy cycles, done pulse on commit.
// start is ignored while busy (no queueing); MTHI/MTLO complete in one cycle from IDLE.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITERS = WIDTH;
  localparam int CW    = $clog2(ITERS);

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_done;
  logic [WIDTH-1:0]   r_opd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;

  state_e             w_state_nxt;
  logic               w_busy;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic [2*WIDTH-1:0] w_p_fix;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_sub;

  assign w_a_neg = op_is_signed(op) & rs_val[WIDTH-1];
  assign w_b_neg = op_is_signed(op) & rt_val[WIDTH-1];

  cond_negate #(.W(WIDTH)) u_a_mag (.i_neg(w_a_neg), .i_dat(rs_val), .o_dat(w_a_mag));
  cond_negate #(.W(WIDTH)) u_b_mag (.i_neg(w_b_neg), .i_dat(rt_val), .o_dat(w_b_mag));

  cond_negate #(.W(WIDTH)) u_q_fix (.i_neg(r_neg_q), .i_dat(r_acc[WIDTH-1:0]),       .o_dat(w_q_fix));
  cond_negate #(.W(WIDTH)) u_r_fix (.i_neg(r_neg_r), .i_dat(r_acc[2*WIDTH-1:WIDTH]), .o_dat(w_r_fix));
  cond_negate #(.W(2*WIDTH)) u_p_fix (.i_neg(r_neg_q), .i_dat(r_acc), .o_dat(w_p_fix));

  // Multiply keeps {partial, multiplier} in r_acc; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    w_add    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
    w_sub    = w_rem_sh - {1'b0, r_opd};
    if (r_is_div) begin
      if (w_sub[WIDTH])
        w_acc_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      else
        w_acc_step = {w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_step = {w_add, r_acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (start && op_is_iter(op)) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CW'(ITERS - 1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_opd    <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && op_is_iter(op)) begin
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= op[1] && (rt_val == '0);
            r_opd    <= op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
          end else if (start && (op == OP_MTHI)) begin
            r_hi   <= rs_val;
            r_done <= 1'b1;
          end else if (start && (op == OP_MTLO)) begin
            r_lo   <= rs_val;
            r_done <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            // A zero divisor leaves |A| as remainder; re-applying A's sign restores rs_val exactly.
            r_hi <= w_r_fix;
            r_lo <= r_div0 ? '1 : w_q_fix;
          end else begin
            {r_hi, r_lo} <= w_p_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed vector table, hand sequences, random ops vs arithmetic model.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; division truncates toward zero with remainder sign of dividend.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hin, input logic [31:0] lin,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = hin;
    el = lin;
    case (o)
      3'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
      3'd2: begin
        if (b == 0) begin eh = a; el = '1; end
        else begin
          sq = sa / sb; sr = sa % sb;
          p = 64'(sq); el = p[31:0];
          p = 64'(sr); eh = p[31:0];
        end
      end
      3'd3: begin
        if (b == 0) begin eh = a; el = '1; end
        else begin el = a / b; eh = a % b; end
      end
      3'd4: eh = a;
      3'd5: el = a;
      default: ;
    endcase
  endtask

  // Issues one op in the current cycle and checks timing, handshake and HI/LO.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic inject, input logic [31:0] eh, input logic [31:0] el,
                       input string nm);
    int          edges;
    int          busyc;
    logic        stable;
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; stable = 1'b1;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    start = 1'b0;
    edges = 1; busyc = 0;
    if (o >= 3'd4) begin
      chk({nm, "_done"}, done, (o <= 3'd5));
      chk({nm, "_busy"}, busy, 0);
    end else begin
      while (!done && edges < 60) begin
        if (busy) busyc++;
        if (hi !== h0 || lo !== l0) stable = 1'b0;
        start = inject && (edges == 4);
        if (start) begin op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7; end
        tick();
        edges++;
      end
      start = 1'b0;
      chk({nm, "_latency"}, edges, 34);
      chk({nm, "_busy_cycles"}, busyc, 33);
      chk({nm, "_busy_low"}, busy, 0);
      chk({nm, "_hilo_stable"}, stable, 1);
    end
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 20));
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] eh, el, a, b;
    logic [2:0]  o;
    logic        quiet;

    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{OP_DIV,   32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[6]  = '{OP_MULT,  32'd5,         32'd7,         32'd0,         32'd35};
    vecs[7]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8]  = '{OP_DIVU,  32'd5,         32'd10,        32'd5,         32'd0};
    vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF};

    rst_n = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    rst_n = 1'b1;

    // Reset in the middle of a multiply discards it and clears HI/LO.
    do_op(OP_MTHI, 32'h0000_1111, 32'd0, 1'b0, 32'h0000_1111, 32'd0, "pre_reset_mthi");
    start = 1'b1; op = OP_MULT; rs_val = 32'd5; rt_val = 32'd7;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_hi", hi, 0);
    chk("midreset_lo", lo, 0);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done || busy) quiet = 1'b0;
    end
    chk("midreset_no_done", quiet, 1);
    m_hi = '0; m_lo = '0;

    for (int i = 0; i < 11; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].eh, vecs[i].el, $sformatf("vec%0d", i));

    // -3 x 7 with a DIVU start pulse landing at cycle 5 while busy.
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_inject");

    // MTHI, MTLO, then MULT, each issued in the previous op's done cycle.
    do_op(OP_MTHI, 32'hA5A5_A5A5, 32'd0, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_FFEB, "mthi");
    do_op(OP_MTLO, 32'd1, 32'd0, 1'b0, 32'hA5A5_A5A5, 32'd1, "mtlo");
    do_op(OP_MULT, 32'd6, 32'd7, 1'b0, 32'd0, 32'd42, "b2b_mult");

    do_op(3'd6, 32'hDEAD_BEEF, 32'd3, 1'b0, 32'd0, 32'd42, "rsvd6");
    do_op(3'd7, 32'hDEAD_BEEF, 32'd3, 1'b0, 32'd0, 32'd42, "rsvd7");

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      model(o, a, b, m_hi, m_lo, eh, el);
      do_op(o, a, b, 1'b0, eh, el, $sformatf("rnd%0d_op%0d", i, o));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
